// File: rtl/mem_port_arbiter.sv
// Shared memory port sequencer for the multicycle CPU: arbitrates fetch vs data
// access, tracks wait states with a timeout abort, and strobes the IR/MDR enables.
module mem_port_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic        mem_rdy,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        ir_ce,
  output logic        mdr_ce,
  output logic        if_done,
  output logic        dm_done,
  output logic        bus_err,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IF_ACC = 2'd1;
  localparam logic [1:0] DM_ACC = 2'd2;
  localparam logic [1:0] ERR    = 2'd3;

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic          last_dm;
  logic [CW-1:0] wait_cnt;
  logic          grant_dm;
  logic          grant_if;
  logic          in_access;

  // Round-robin grant; only acted upon in IDLE
  always_comb begin
    grant_dm = 1'b0;
    grant_if = 1'b0;
    if (dm_req && if_req) begin
      if (last_dm) begin
        grant_if = 1'b1;
      end else begin
        grant_dm = 1'b1;
      end
    end else if (dm_req) begin
      grant_dm = 1'b1;
    end else if (if_req) begin
      grant_if = 1'b1;
    end else begin
      grant_dm = 1'b0;
      grant_if = 1'b0;
    end
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_dm) begin
          next_state = DM_ACC;
        end else if (grant_if) begin
          next_state = IF_ACC;
        end else begin
          next_state = IDLE;
        end
      end
      IF_ACC, DM_ACC: begin
        if (mem_rdy) begin
          next_state = IDLE;
        end else if (wait_cnt == LIMIT) begin
          next_state = ERR;
        end else begin
          next_state = state;
        end
      end
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, grant history, wait counter and the registered port fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_dm   <= 1'b0;
      wait_cnt  <= '0;
      mem_addr  <= 32'h0000_0000;
      mem_we    <= 1'b0;
      mem_wdata <= 32'h0000_0000;
    end else begin
      state <= next_state;
      if (state == IDLE && grant_dm) begin
        last_dm   <= 1'b1;
        wait_cnt  <= '0;
        mem_addr  <= dm_addr;
        mem_we    <= dm_we;
        mem_wdata <= dm_wdata;
      end else if (state == IDLE && grant_if) begin
        last_dm  <= 1'b0;
        wait_cnt <= '0;
        mem_addr <= if_addr;
        mem_we   <= 1'b0;
      end else if (in_access && !mem_rdy) begin
        // Leaves the access state at LIMIT, so this never exceeds TIMEOUT
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  // last_dm doubles as the owner of the current or aborted access
  assign in_access = (state == IF_ACC) || (state == DM_ACC);
  assign mem_cs    = in_access;
  assign busy      = (state != IDLE);
  assign bus_err   = (state == ERR);
  assign ir_ce     = (state == IF_ACC) && mem_rdy;
  assign mdr_ce    = (state == DM_ACC) && mem_rdy && !mem_we;
  assign if_done   = ((state == IF_ACC) && mem_rdy) || ((state == ERR) && !last_dm);
  assign dm_done   = ((state == DM_ACC) && mem_rdy) || ((state == ERR) && last_dm);

endmodule
